// File: rtl/bch_channel_ctrl.sv
// bch_channel_ctrl
//   Sequences one BCH transmission run: encode -> noise -> error injection
//   -> decode -> report. Each stage is optional, selected by the cfg_* fields
//   that are sampled at start. Noise and random error positions come from a
//   16-bit Galois LFSR that advances only during the NOISE and ERRORS stages.
//   Encoder/decoder handshakes are bounded by TIMEOUT.
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start                   1-cycle run request (ignored while busy)
//   i_cfg_*                   stage enables, error mode, requested error count
//   i_data_in [K]             payload
//   o_enc_start/o_enc_data    encoder request; i_enc_done/i_enc_code response
//   o_dec_start/o_dec_code    decoder request; i_dec_done/i_dec_data/i_dec_fail response
//   o_busy, o_done            run in progress, 1-cycle end-of-run pulse
//   o_data_out, o_err_injected, o_mismatch, o_timeout   run results
//   o_run_count [16]          completed runs (wrapping)
module bch_channel_ctrl #(
  parameter int unsigned K         = 7,
  parameter int unsigned N         = 15,
  parameter int unsigned MAX_ERR   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_cfg_bch_en,
  input  logic         i_cfg_noise_en,
  input  logic         i_cfg_rand_err_en,
  input  logic [7:0]   i_cfg_num_err,
  input  logic [K-1:0] i_data_in,
  output logic         o_enc_start,
  output logic [K-1:0] o_enc_data,
  input  logic         i_enc_done,
  input  logic [N-1:0] i_enc_code,
  output logic         o_dec_start,
  output logic [N-1:0] o_dec_code,
  input  logic         i_dec_done,
  input  logic [K-1:0] i_dec_data,
  input  logic         i_dec_fail,
  output logic         o_busy,
  output logic         o_done,
  output logic [K-1:0] o_data_out,
  output logic [7:0]   o_err_injected,
  output logic         o_mismatch,
  output logic         o_timeout,
  output logic [15:0]  o_run_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ENCODE = 3'd1;
  localparam logic [2:0] S_NOISE  = 3'd2;
  localparam logic [2:0] S_ERRORS = 3'd3;
  localparam logic [2:0] S_DECODE = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [2:0]    r_state, w_state_nxt;
  logic          r_bch, w_bch_nxt, r_noise, w_noise_nxt, r_rand, w_rand_nxt;
  logic [7:0]    r_target, w_target_nxt;
  logic [K-1:0]  r_data, w_data_nxt;
  logic [N-1:0]  r_word, w_word_nxt;
  logic [N-1:0]  r_flipped, w_flipped_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [15:0]   r_lfsr, w_lfsr_nxt;
  logic [7:0]    r_err, w_err_nxt;
  logic [7:0]    r_errs_done, w_errs_done_nxt;
  logic [K-1:0]  r_dec_data, w_dec_data_nxt;
  logic          r_dec_fail, w_dec_fail_nxt, r_dec_valid, w_dec_valid_nxt;
  logic          r_enc_start, w_enc_start_nxt, r_dec_start, w_dec_start_nxt;
  logic [K-1:0]  r_data_out, w_data_out_nxt;
  logic          r_mismatch, w_mismatch_nxt, r_timeout, w_timeout_nxt;
  logic [15:0]   r_run_count, w_run_count_nxt;
  logic [7:0]    w_rpos;
  logic [N-1:0]  w_mask;

  // First enabled stage strictly after 'from'.
  function automatic logic [2:0] f_next(input logic [2:0] from, input logic bch,
                                        input logic noise, input logic errs);
    if (from == S_IDLE && bch)                                   return S_ENCODE;
    if ((from == S_IDLE || from == S_ENCODE) && noise)           return S_NOISE;
    if ((from == S_IDLE || from == S_ENCODE || from == S_NOISE) && errs) return S_ERRORS;
    if (from != S_DECODE && bch)                                 return S_DECODE;
    return S_FINISH;
  endfunction

  function automatic logic [15:0] f_lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  assign w_rpos = r_lfsr[7:0] % 8'(N);

  always_comb begin
    w_state_nxt      = r_state;
    w_bch_nxt        = r_bch;
    w_noise_nxt      = r_noise;
    w_rand_nxt       = r_rand;
    w_target_nxt     = r_target;
    w_data_nxt       = r_data;
    w_word_nxt       = r_word;
    w_flipped_nxt    = r_flipped;
    w_cnt_nxt        = r_cnt;
    w_lfsr_nxt       = r_lfsr;
    w_err_nxt        = r_err;
    w_errs_done_nxt  = r_errs_done;
    w_dec_data_nxt   = r_dec_data;
    w_dec_fail_nxt   = r_dec_fail;
    w_dec_valid_nxt  = r_dec_valid;
    w_enc_start_nxt  = 1'b0;
    w_dec_start_nxt  = 1'b0;
    w_data_out_nxt   = r_data_out;
    w_mismatch_nxt   = r_mismatch;
    w_timeout_nxt    = r_timeout;
    w_run_count_nxt  = r_run_count;
    w_mask           = '0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_bch_nxt          = i_cfg_bch_en;
          w_noise_nxt        = i_cfg_noise_en;
          w_rand_nxt         = i_cfg_rand_err_en;
          w_target_nxt       = (i_cfg_num_err > 8'(MAX_ERR)) ? 8'(MAX_ERR) : i_cfg_num_err;
          w_data_nxt         = i_data_in;
          w_word_nxt         = '0;
          w_word_nxt[K-1:0]  = i_data_in;
          w_flipped_nxt      = '0;
          w_err_nxt          = '0;
          w_errs_done_nxt    = '0;
          w_dec_data_nxt     = '0;
          w_dec_fail_nxt     = 1'b0;
          w_dec_valid_nxt    = 1'b0;
          w_data_out_nxt     = '0;
          w_mismatch_nxt     = 1'b0;
          w_timeout_nxt      = 1'b0;
          w_state_nxt = f_next(S_IDLE, i_cfg_bch_en, i_cfg_noise_en, i_cfg_num_err != 8'd0);
        end
      end
      S_ENCODE: begin
        if (i_enc_done) begin
          w_word_nxt  = i_enc_code;
          w_state_nxt = f_next(S_ENCODE, r_bch, r_noise, r_target != 8'd0);
        end else if (r_cnt == CW'(TIMEOUT)) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_FINISH;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_NOISE: begin
        w_lfsr_nxt = f_lfsr_step(r_lfsr);
        if (r_lfsr[3:0] == 4'd0) begin
          w_word_nxt = r_word ^ (ONE << r_cnt);
          w_err_nxt  = r_err + 8'd1;
        end
        if (r_cnt == CW'(N - 1))
          w_state_nxt = f_next(S_NOISE, r_bch, r_noise, r_target != 8'd0);
        else
          w_cnt_nxt = r_cnt + CW'(1);
      end
      S_ERRORS: begin
        w_lfsr_nxt = f_lfsr_step(r_lfsr);
        w_mask     = ONE << (r_rand ? w_rpos : r_errs_done);
        // Only positions already hit by this stage are skipped; noise flips may be re-flipped.
        if (!r_rand || (r_flipped & w_mask) == '0) begin
          w_word_nxt      = r_word ^ w_mask;
          w_flipped_nxt   = r_flipped | w_mask;
          w_err_nxt       = r_err + 8'd1;
          w_errs_done_nxt = r_errs_done + 8'd1;
          if (r_errs_done + 8'd1 == r_target)
            w_state_nxt = f_next(S_ERRORS, r_bch, r_noise, 1'b1);
        end
      end
      S_DECODE: begin
        if (i_dec_done) begin
          w_dec_data_nxt  = i_dec_data;
          w_dec_fail_nxt  = i_dec_fail;
          w_dec_valid_nxt = 1'b1;
          w_state_nxt     = S_FINISH;
        end else if (r_cnt == CW'(TIMEOUT)) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_FINISH;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    // Results are formed from the next-state values so they are valid alongside done.
    if (w_state_nxt == S_FINISH && r_state != S_FINISH) begin
      w_data_out_nxt  = w_dec_valid_nxt ? w_dec_data_nxt : w_word_nxt[K-1:0];
      w_mismatch_nxt  = (w_data_out_nxt != w_data_nxt) || w_dec_fail_nxt;
      w_run_count_nxt = r_run_count + 16'd1;
    end

    if (w_state_nxt != r_state) begin
      w_cnt_nxt       = '0;
      w_enc_start_nxt = (w_state_nxt == S_ENCODE);
      w_dec_start_nxt = (w_state_nxt == S_DECODE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_bch       <= 1'b0;
      r_noise     <= 1'b0;
      r_rand      <= 1'b0;
      r_target    <= '0;
      r_data      <= '0;
      r_word      <= '0;
      r_flipped   <= '0;
      r_cnt       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_err       <= '0;
      r_errs_done <= '0;
      r_dec_data  <= '0;
      r_dec_fail  <= 1'b0;
      r_dec_valid <= 1'b0;
      r_enc_start <= 1'b0;
      r_dec_start <= 1'b0;
      r_data_out  <= '0;
      r_mismatch  <= 1'b0;
      r_timeout   <= 1'b0;
      r_run_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bch       <= w_bch_nxt;
      r_noise     <= w_noise_nxt;
      r_rand      <= w_rand_nxt;
      r_target    <= w_target_nxt;
      r_data      <= w_data_nxt;
      r_word      <= w_word_nxt;
      r_flipped   <= w_flipped_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_err       <= w_err_nxt;
      r_errs_done <= w_errs_done_nxt;
      r_dec_data  <= w_dec_data_nxt;
      r_dec_fail  <= w_dec_fail_nxt;
      r_dec_valid <= w_dec_valid_nxt;
      r_enc_start <= w_enc_start_nxt;
      r_dec_start <= w_dec_start_nxt;
      r_data_out  <= w_data_out_nxt;
      r_mismatch  <= w_mismatch_nxt;
      r_timeout   <= w_timeout_nxt;
      r_run_count <= w_run_count_nxt;
    end
  end

  assign o_enc_start    = r_enc_start;
  assign o_enc_data     = r_data;
  assign o_dec_start    = r_dec_start;
  assign o_dec_code     = r_word;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_FINISH);
  assign o_data_out     = r_data_out;
  assign o_err_injected = r_err;
  assign o_mismatch     = r_mismatch;
  assign o_timeout      = r_timeout;
  assign o_run_count    = r_run_count;

endmodule

// File: tb/tb_bch_channel_ctrl.sv
module tb_bch_channel_ctrl;
  localparam int unsigned K  = 7;
  localparam int unsigned N  = 15;
  localparam int unsigned TO = 20;

  logic         clk = 1'b0;
  logic         i_rst_n, i_start, i_cfg_bch_en, i_cfg_noise_en, i_cfg_rand_err_en;
  logic [7:0]   i_cfg_num_err;
  logic [K-1:0] i_data_in;
  logic         o_enc_start, o_dec_start, o_busy, o_done, o_mismatch, o_timeout;
  logic [K-1:0] o_enc_data, o_data_out;
  logic         i_enc_done, i_dec_done, i_dec_fail;
  logic [N-1:0] i_enc_code, o_dec_code;
  logic [K-1:0] i_dec_data;
  logic [7:0]   o_err_injected;
  logic [15:0]  o_run_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // responder state (written only by the responder process)
  int n_enc = 0, n_dec = 0, n_done = 0, t_enc = 0, enc_wait = 0, dec_wait = 0;
  logic [K-1:0] enc_data_cap;
  logic [N-1:0] dec_code_cap;
  // responder controls (written only by the stimulus process)
  logic enc_respond;
  logic dec_fail_val;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bch_channel_ctrl #(.K(K), .N(N), .MAX_ERR(4), .LFSR_SEED(16'hACE1), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_cfg_bch_en(i_cfg_bch_en), .i_cfg_noise_en(i_cfg_noise_en),
    .i_cfg_rand_err_en(i_cfg_rand_err_en), .i_cfg_num_err(i_cfg_num_err),
    .i_data_in(i_data_in),
    .o_enc_start(o_enc_start), .o_enc_data(o_enc_data),
    .i_enc_done(i_enc_done), .i_enc_code(i_enc_code),
    .o_dec_start(o_dec_start), .o_dec_code(o_dec_code),
    .i_dec_done(i_dec_done), .i_dec_data(i_dec_data), .i_dec_fail(i_dec_fail),
    .o_busy(o_busy), .o_done(o_done), .o_data_out(o_data_out),
    .o_err_injected(o_err_injected), .o_mismatch(o_mismatch),
    .o_timeout(o_timeout), .o_run_count(o_run_count)
  );

  // Encoder answers 15'h2D5A three cycles after enc_start; decoder answers 7'h5A two cycles after dec_start.
  always @(negedge clk) begin
    i_enc_done = 1'b0;
    i_dec_done = 1'b0;
    if (enc_wait != 0) begin
      enc_wait--;
      if (enc_wait == 0) begin
        i_enc_done = 1'b1;
        i_enc_code = 15'h2D5A;
      end
    end
    if (dec_wait != 0) begin
      dec_wait--;
      if (dec_wait == 0) begin
        i_dec_done = 1'b1;
        i_dec_data = 7'h5A;
        i_dec_fail = dec_fail_val;
      end
    end
    if (o_enc_start) begin
      n_enc++;
      t_enc = cyc;
      enc_data_cap = o_enc_data;
      if (enc_respond) enc_wait = 3;
    end
    if (o_dec_start) begin
      n_dec++;
      dec_code_cap = o_dec_code;
      dec_wait = 2;
    end
    if (o_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_start(input logic bch, input logic noise, input logic rnd,
                           input logic [7:0] nerr, input logic [K-1:0] data);
    i_cfg_bch_en      = bch;
    i_cfg_noise_en    = noise;
    i_cfg_rand_err_en = rnd;
    i_cfg_num_err     = nerr;
    i_data_in         = data;
    i_start           = 1'b1;
    @(negedge clk);
    i_start           = 1'b0;
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int k = 0; k < 200; k++) begin
      if (o_done) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", 32'(t >= 0), 1);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick(2);
    i_rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int t, b_enc, b_dec, b_done;
    i_rst_n = 1'b0; i_start = 1'b0;
    i_cfg_bch_en = 1'b0; i_cfg_noise_en = 1'b0; i_cfg_rand_err_en = 1'b0;
    i_cfg_num_err = 8'd0; i_data_in = '0;
    enc_respond = 1'b1; dec_fail_val = 1'b0;
    tick(3);

    // reset state
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_data_out", 32'(o_data_out), 0);
    chk("rst_err", 32'(o_err_injected), 0);
    chk("rst_mismatch", 32'(o_mismatch), 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    chk("rst_run_count", 32'(o_run_count), 0);
    chk("rst_enc_start", 32'(o_enc_start), 0);
    chk("rst_dec_start", 32'(o_dec_start), 0);
    chk("rst_dec_code", 32'(o_dec_code), 0);
    i_rst_n = 1'b1;
    tick(2);

    // encode + decode round trip
    b_enc = n_enc; b_dec = n_dec;
    run_start(1'b1, 1'b0, 1'b0, 8'd0, 7'h5A);
    wait_done(t);
    chk("a_data_out", 32'(o_data_out), 32'h5A);
    chk("a_mismatch", 32'(o_mismatch), 0);
    chk("a_run_count", 32'(o_run_count), 1);
    chk("a_err", 32'(o_err_injected), 0);
    chk("a_busy_in_finish", 32'(o_busy), 1);
    tick(1);
    chk("a_busy_after", 32'(o_busy), 0);
    chk("a_done_width", 32'(o_done), 0);
    chk("a_enc_pulses", 32'(n_enc - b_enc), 1);
    chk("a_dec_pulses", 32'(n_dec - b_dec), 1);
    chk("a_enc_data", 32'(enc_data_cap), 32'h5A);
    chk("a_dec_code", 32'(dec_code_cap), 32'h2D5A);

    // decoder failure flags mismatch even with matching payload
    dec_fail_val = 1'b1;
    run_start(1'b1, 1'b0, 1'b0, 8'd0, 7'h5A);
    wait_done(t);
    chk("f_data_out", 32'(o_data_out), 32'h5A);
    chk("f_mismatch", 32'(o_mismatch), 1);
    chk("f_run_count", 32'(o_run_count), 2);
    dec_fail_val = 1'b0;
    tick(1);

    // deterministic errors without bch
    b_enc = n_enc; b_dec = n_dec;
    run_start(1'b0, 1'b0, 1'b0, 8'd3, 7'h00);
    wait_done(t);
    chk("b_data_out", 32'(o_data_out), 32'h07);
    chk("b_err", 32'(o_err_injected), 3);
    chk("b_mismatch", 32'(o_mismatch), 1);
    chk("b_run_count", 32'(o_run_count), 3);
    tick(1);
    chk("b_no_enc", 32'(n_enc - b_enc), 0);
    chk("b_no_dec", 32'(n_dec - b_dec), 0);

    // start while busy and cfg changed mid-run; start during FINISH ignored
    b_enc = n_enc; b_dec = n_dec; b_done = n_done;
    run_start(1'b1, 1'b0, 1'b0, 8'd0, 7'h5A);
    i_cfg_bch_en = 1'b0; i_data_in = 7'h11; i_cfg_num_err = 8'd5;
    tick(1);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    wait_done(t);
    chk("g_data_out", 32'(o_data_out), 32'h5A);
    chk("g_mismatch", 32'(o_mismatch), 0);
    chk("g_run_count", 32'(o_run_count), 4);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    chk("g_finish_start_ignored", 32'(o_busy), 0);
    tick(5);
    chk("g_run_count_hold", 32'(o_run_count), 4);
    chk("g_done_pulses", 32'(n_done - b_done), 1);
    chk("g_enc_pulses", 32'(n_enc - b_enc), 1);
    chk("g_dec_pulses", 32'(n_dec - b_dec), 1);
    chk("g_data_hold", 32'(o_data_out), 32'h5A);

    // encoder never answers
    enc_respond = 1'b0;
    b_dec = n_dec;
    run_start(1'b1, 1'b0, 1'b0, 8'd0, 7'h5A);
    wait_done(t);
    chk("t_timeout", 32'(o_timeout), 1);
    chk("t_latency", 32'(t - t_enc), TO + 1);
    chk("t_run_count", 32'(o_run_count), 5);
    tick(1);
    chk("t_no_dec", 32'(n_dec - b_dec), 0);
    enc_respond = 1'b1;
    run_start(1'b0, 1'b0, 1'b0, 8'd1, 7'h00);
    chk("t_clear_on_start", 32'(o_timeout), 0);
    chk("t_busy_after_start", 32'(o_busy), 1);
    wait_done(t);
    chk("t_next_run_count", 32'(o_run_count), 6);

    // noise pass then deterministic errors over a fresh LFSR: noise hits bit 1 only
    do_reset();
    run_start(1'b0, 1'b1, 1'b0, 8'd2, 7'h00);
    wait_done(t);
    chk("n_word", 32'(o_dec_code), 32'h0001);
    chk("n_err", 32'(o_err_injected), 3);
    chk("n_data_out", 32'(o_data_out), 32'h01);
    chk("n_run_count", 32'(o_run_count), 1);

    // random errors capped at MAX_ERR: positions 0,7,11,6 from the seed
    do_reset();
    b_enc = n_enc;
    run_start(1'b0, 1'b0, 1'b1, 8'd200, 7'h00);
    wait_done(t);
    chk("c_word", 32'(o_dec_code), 32'h08C1);
    chk("c_err", 32'(o_err_injected), 4);
    chk("c_data_out", 32'(o_data_out), 32'h41);
    chk("c_mismatch", 32'(o_mismatch), 1);
    chk("c_run_count", 32'(o_run_count), 1);
    tick(1);
    chk("c_no_enc", 32'(n_enc - b_enc), 0);

    do_reset();
    run_start(1'b0, 1'b0, 1'b1, 8'd200, 7'h00);
    wait_done(t);
    chk("c2_word", 32'(o_dec_code), 32'h08C1);
    chk("c2_err", 32'(o_err_injected), 4);

    // reset in the middle of ERRORS
    tick(1);
    b_done = n_done;
    run_start(1'b0, 1'b0, 1'b1, 8'd200, 7'h00);
    tick(1);
    chk("r_busy_before", 32'(o_busy), 1);
    chk("r_err_before", 32'(o_err_injected), 1);
    i_rst_n = 1'b0;
    #1;
    chk("r_busy", 32'(o_busy), 0);
    chk("r_err", 32'(o_err_injected), 0);
    chk("r_dec_code", 32'(o_dec_code), 0);
    chk("r_run_count", 32'(o_run_count), 0);
    chk("r_done", 32'(o_done), 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    tick(1);
    run_start(1'b0, 1'b0, 1'b1, 8'd200, 7'h00);
    wait_done(t);
    chk("r_word_after", 32'(o_dec_code), 32'h08C1);
    chk("r_err_after", 32'(o_err_injected), 4);
    chk("r_run_count_after", 32'(o_run_count), 1);
    tick(1);
    chk("r_done_pulses", 32'(n_done - b_done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
